// File: rtl/accum_frame_reader_if.sv
// Result stream from accum_frame_reader to the consumer: show-ahead head word plus valid/ready.
interface accum_frame_reader_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/accum_frame_reader.sv
// Tracks the four-slot accumulate sequence, checks slot ordering and queues each finished
// accumulator value into a show-ahead FIFO drained over a valid/ready handshake.
module accum_frame_reader #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = 8
) (
   input  logic                     ph1,
   input  logic                     reset,
   input  logic [1:0]               slot,
   input  logic                     frame_end,
   input  logic [WIDTH-1:0]         accum,
   accum_frame_reader_if.master     res,
   output logic                     locked,
   output logic                     seq_err,
   output logic [CNTW-1:0]          drop_count,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     err_clr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   typedef enum logic [0:0] {StHunt, StLock} state_e;

   state_e            state_q, state_d;
   logic [1:0]        exp_q, exp_d;
   logic              seq_fault, frame_ok;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]       level_q, level_d;
   logic [WIDTH-1:0]  out_data_q, head_d;
   logic              seq_err_q, seq_err_d;
   logic [CNTW-1:0]   drop_q, drop_d;
   logic              pop, push, drop, full;

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      seq_fault = 1'b0;
      frame_ok  = 1'b0;
      unique case (state_q)
         StHunt: begin
            // The frame that ends here was not seen from its start, so it is not captured.
            if (slot == 2'd3 && frame_end) begin
               state_d = StLock;
               exp_d   = 2'd0;
            end
         end
         StLock: begin
            seq_fault = (slot != exp_q) || (frame_end != (slot == 2'd3));
            if (seq_fault) begin
               state_d = StHunt;
               exp_d   = 2'd0;
            end else begin
               exp_d    = exp_q + 2'd1;
               frame_ok = frame_end;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q <= StHunt;
         exp_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
      end
   end

   assign full = (level_q == LW'(DEPTH));
   assign pop  = (level_q != '0) && res.out_ready;
   assign push = frame_ok && (!full || pop);
   assign drop = frame_ok && full && !pop;

   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      level_d  = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      // The word written this cycle becomes the head only when it lands where the head points.
      head_d = (push && wr_ptr_q == rd_ptr_d) ? accum : mem_q[rd_ptr_d];
   end

   always_comb begin
      seq_err_d = seq_fault | (seq_err_q & ~err_clr);
      drop_d    = drop_q;
      if (drop) begin
         if (err_clr) drop_d = {{(CNTW-1){1'b0}}, 1'b1};
         else if (!(&drop_q)) drop_d = drop_q + 1'b1;
      end else if (err_clr) begin
         drop_d = '0;
      end
   end

   always_ff @(posedge ph1) begin
      if (push) mem_q[wr_ptr_q] <= accum;
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         out_data_q <= '0;
         seq_err_q  <= 1'b0;
         drop_q     <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         level_q   <= level_d;
         seq_err_q <= seq_err_d;
         drop_q    <= drop_d;
         if (level_d != '0) out_data_q <= head_d;
      end
   end

   assign res.out_data  = out_data_q;
   assign res.out_valid = (level_q != '0);
   assign locked        = (state_q == StLock);
   assign seq_err       = seq_err_q;
   assign drop_count    = drop_q;
   assign level         = level_q;

endmodule
